// File: rtl/div_seq.sv
// ---------------------------------------------------------------------------
// div_seq
//   Multicycle radix-2 restoring integer divider for the HI/LO unit.
//   Produces one quotient bit per clock. Latency is fixed at WIDTH+1 edges
//   from an accepted start for a nonzero divisor, and 1 edge for a zero
//   divisor. The latency does not depend on the operand values or on the
//   signed/unsigned mode.
//
// Ports
//   clk_i         clock; all state changes on the rising edge
//   reset_i       synchronous, active-high reset
//   start_i       operation request; only sampled while idle
//   div_signed_i  1 = two's-complement operands, 0 = unsigned
//   dividend_i    numerator, captured with start
//   divisor_i     denominator, captured with start
//   busy_o        operation in progress
//   done_o        one-cycle pulse; hi_o/lo_o hold the new results
//   div_zero_o    last operation had a zero divisor (held until next start)
//   hi_o          remainder (takes the sign of the dividend)
//   lo_o          quotient (truncated toward zero)
// ---------------------------------------------------------------------------
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             div_signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  // Partial remainder carries one extra bit so the shifted value can be
  // compared against the divisor magnitude without overflowing.
  logic [WIDTH:0]     rem_q;
  // Holds the dividend magnitude at start; quotient bits shift in from the
  // bottom while dividend bits leave from the top.
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   dvs_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               neg_quo_q;
  logic               neg_rem_q;
  logic               zero_q;
  logic               busy_q;
  logic               done_q;
  logic               div_zero_q;

  logic               dvd_neg_d;
  logic               dvs_neg_d;
  logic [WIDTH-1:0]   dvd_mag_d;
  logic [WIDTH-1:0]   dvs_mag_d;
  logic [WIDTH:0]     shift_d;
  logic [WIDTH:0]     rem_d;
  logic [WIDTH-1:0]   quo_d;
  logic               ge_d;
  logic [WIDTH-1:0]   lo_d;
  logic [WIDTH-1:0]   hi_d;

  // The remainder never reaches the top bit after a step, so only the
  // low WIDTH bits are shifted back in.
  logic               unused_rem_msb;
  assign unused_rem_msb = rem_q[WIDTH];

  always_comb begin
    dvd_neg_d = div_signed_i & dividend_i[WIDTH-1];
    dvs_neg_d = div_signed_i & divisor_i[WIDTH-1];
    // The most-negative value maps onto itself, which is its correct
    // unsigned magnitude.
    dvd_mag_d = dvd_neg_d ? -dividend_i : dividend_i;
    dvs_mag_d = dvs_neg_d ? -divisor_i  : divisor_i;

    shift_d   = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    ge_d      = (shift_d >= {1'b0, dvs_q});
    rem_d     = ge_d ? (shift_d - {1'b0, dvs_q}) : shift_d;
    quo_d     = {quo_q[WIDTH-2:0], ge_d};

    lo_d      = neg_quo_q ? -quo_q : quo_q;
    hi_d      = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      zero_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            div_zero_q <= 1'b0;
            busy_q     <= 1'b1;
            if (divisor_i == '0) begin
              // Preload the FIX stage so it emits all-ones / raw dividend
              // through the same path as a normal result.
              zero_q    <= 1'b1;
              rem_q     <= {1'b0, dividend_i};
              quo_q     <= '1;
              dvs_q     <= '0;
              neg_quo_q <= 1'b0;
              neg_rem_q <= 1'b0;
              state_q   <= FIX;
            end else begin
              zero_q    <= 1'b0;
              rem_q     <= '0;
              quo_q     <= dvd_mag_d;
              dvs_q     <= dvs_mag_d;
              neg_quo_q <= dvd_neg_d ^ dvs_neg_d;
              neg_rem_q <= dvd_neg_d;
              cnt_q     <= CNT_W'(WIDTH - 1);
              state_q   <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          if (cnt_q == '0) begin
            state_q <= FIX;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        FIX: begin
          lo_q       <= lo_d;
          hi_q       <= hi_d;
          div_zero_q <= zero_q;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign div_zero_o = div_zero_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule

// File: tb/tb_div_seq.sv
// ---------------------------------------------------------------------------
// tb_div_seq
//   Self-checking bench for div_seq: a WIDTH=32 instance driven from a table
//   of hand-computed vectors plus directed handshake/reset sequences, and a
//   WIDTH=8 instance with directed and random operands checked against the
//   language's own truncating division.
// ---------------------------------------------------------------------------
module tb_div_seq;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;

  logic        start32, sgn32;
  logic [31:0] a32, b32;
  logic        busy32, done32, z32;
  logic [31:0] hi32, lo32;

  logic        start8, sgn8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, z8;
  logic [7:0]  hi8, lo8;

  int n_checks = 0;
  int n_fail   = 0;

  div_seq #(.WIDTH(32)) dut32 (
    .clk_i(clk), .reset_i(reset), .start_i(start32), .div_signed_i(sgn32),
    .dividend_i(a32), .divisor_i(b32), .busy_o(busy32), .done_o(done32),
    .div_zero_o(z32), .hi_o(hi32), .lo_o(lo32)
  );

  div_seq #(.WIDTH(8)) dut8 (
    .clk_i(clk), .reset_i(reset), .start_i(start8), .div_signed_i(sgn8),
    .dividend_i(a8), .divisor_i(b8), .busy_o(busy8), .done_o(done8),
    .div_zero_o(z8), .hi_o(hi8), .lo_o(lo8)
  );

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_lo;
    logic [31:0] exp_hi;
    logic        exp_z;
    int          exp_lat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at #1 after a rising edge with the divider idle.
  task automatic op32(input string name, input logic s, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp_lo,
                      input logic [31:0] exp_hi, input logic exp_z, input int exp_lat);
    int lat;
    sgn32 = s; a32 = a; b32 = b; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    check({name, "/busy_after_accept"}, 64'(busy32), 64'd1);
    lat = 0;
    while (lat < 50) begin
      @(posedge clk); #1;
      lat++;
      if (done32) break;
    end
    check({name, "/done_seen"}, 64'(done32), 64'd1);
    check({name, "/latency"}, 64'(lat), 64'(exp_lat));
    check({name, "/busy_in_done"}, 64'(busy32), 64'd0);
    check({name, "/lo"}, 64'(lo32), 64'(exp_lo));
    check({name, "/hi"}, 64'(hi32), 64'(exp_hi));
    check({name, "/div_zero"}, 64'(z32), 64'(exp_z));
    @(posedge clk); #1;
    check({name, "/done_one_cycle"}, 64'(done8 | done32), 64'd0);
    $display("op32 %-10s sgn=%0d 0x%08h / 0x%08h -> lo=0x%08h hi=0x%08h z=%0d lat=%0d",
             name, s, a, b, lo32, hi32, z32, lat);
  endtask

  task automatic op8(input string name, input logic s, input logic [7:0] a,
                     input logic [7:0] b, input logic [7:0] exp_lo,
                     input logic [7:0] exp_hi, input logic exp_z, input int exp_lat,
                     input bit verbose);
    int lat;
    sgn8 = s; a8 = a; b8 = b; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (done8) break;
    end
    check({name, "/done_seen"}, 64'(done8), 64'd1);
    check({name, "/latency"}, 64'(lat), 64'(exp_lat));
    check({name, "/busy_in_done"}, 64'(busy8), 64'd0);
    check({name, "/lo"}, 64'(lo8), 64'(exp_lo));
    check({name, "/hi"}, 64'(hi8), 64'(exp_hi));
    check({name, "/div_zero"}, 64'(z8), 64'(exp_z));
    if (verbose)
      $display("op8  %-10s sgn=%0d 0x%02h / 0x%02h -> lo=0x%02h hi=0x%02h z=%0d lat=%0d",
               name, s, a, b, lo8, hi8, z8, lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int dones;
    logic [7:0] ra, rb, elo, ehi;
    logic ez;
    int sa, sb, q, r;

    vecs[0]  = '{"u101/10",  1'b0, 32'd101,        32'd10,         32'd10,         32'd1,          1'b0, 33};
    vecs[1]  = '{"u20/4",    1'b0, 32'd20,         32'd4,          32'd5,          32'd0,          1'b0, 33};
    vecs[2]  = '{"umax/1",   1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 33};
    vecs[3]  = '{"s-7/2",    1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 33};
    vecs[4]  = '{"s7/-2",    1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 33};
    vecs[5]  = '{"s-7/-2",   1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0, 33};
    vecs[6]  = '{"u-7/2",    1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          1'b0, 33};
    vecs[7]  = '{"sovf",     1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 33};
    vecs[8]  = '{"u20/0",    1'b0, 32'd20,         32'd0,          32'hFFFF_FFFF,  32'd20,         1'b1, 1};
    vecs[9]  = '{"u9/3clr",  1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0, 33};
    vecs[10] = '{"s-20/0",   1'b1, 32'hFFFF_FFEC,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFEC,  1'b1, 1};

    reset = 1'b1;
    start32 = 1'b0; sgn32 = 1'b0; a32 = '0; b32 = '0;
    start8  = 1'b0; sgn8  = 1'b0; a8  = '0; b8  = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    check("reset/busy",     64'(busy32), 64'd0);
    check("reset/done",     64'(done32), 64'd0);
    check("reset/div_zero", 64'(z32),    64'd0);
    check("reset/hi",       64'(hi32),   64'd0);
    check("reset/lo",       64'(lo32),   64'd0);
    $display("reset: busy=%0d done=%0d z=%0d hi=0x%0h lo=0x%0h", busy32, done32, z32, hi32, lo32);

    for (int i = 0; i < 11; i++) begin
      op32(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b,
           vecs[i].exp_lo, vecs[i].exp_hi, vecs[i].exp_z, vecs[i].exp_lat);
    end

    // start pulsed mid-calculation with other operands must be ignored
    sgn32 = 1'b0; a32 = 32'd100; b32 = 32'd7; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    a32 = 32'd50; b32 = 32'd5; sgn32 = 1'b1; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    lat = 5;
    while (lat < 50) begin
      @(posedge clk); #1;
      lat++;
      if (done32) break;
    end
    check("midstart/latency", 64'(lat), 64'd33);
    check("midstart/lo", 64'(lo32), 64'd14);
    check("midstart/hi", 64'(hi32), 64'd2);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done32) dones++;
    end
    check("midstart/no_extra_done", 64'(dones), 64'd0);
    $display("midstart: 100/7 with ignored 50/5 -> lo=%0d hi=%0d lat=%0d", lo32, hi32, lat);

    // start held into the done cycle: second operation accepted immediately
    sgn32 = 1'b0; a32 = 32'd100; b32 = 32'd7; start32 = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (lat < 50) begin
      @(posedge clk); #1;
      lat++;
      if (done32) break;
    end
    check("b2b/first_latency", 64'(lat), 64'd33);
    check("b2b/first_lo", 64'(lo32), 64'd14);
    a32 = 32'd45; b32 = 32'd4;
    @(posedge clk); #1;
    start32 = 1'b0;
    check("b2b/busy_no_gap", 64'(busy32), 64'd1);
    lat = 0;
    while (lat < 50) begin
      @(posedge clk); #1;
      lat++;
      if (done32) break;
    end
    check("b2b/second_latency", 64'(lat), 64'd33);
    check("b2b/second_lo", 64'(lo32), 64'd11);
    check("b2b/second_hi", 64'(hi32), 64'd1);
    $display("b2b: 45/4 -> lo=%0d hi=%0d lat=%0d", lo32, hi32, lat);
    @(posedge clk); #1;

    // reset during CALC aborts without a done pulse
    sgn32 = 1'b0; a32 = 32'd200; b32 = 32'd3; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort/busy", 64'(busy32), 64'd0);
    check("abort/hi", 64'(hi32), 64'd0);
    check("abort/lo", 64'(lo32), 64'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done32) dones++;
      @(posedge clk); #1;
    end
    check("abort/no_done", 64'(dones), 64'd0);
    $display("abort: busy=%0d hi=0x%0h lo=0x%0h dones=%0d", busy32, hi32, lo32, dones);
    op32("after_rst", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33);

    // WIDTH=8 instance
    op8("u200/7", 1'b0, 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 9, 1'b1);
    op8("s80/FF", 1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 9, 1'b1);
    op8("u9/0",   1'b0, 8'd9,   8'd0, 8'hFF, 8'd9,  1'b1, 1, 1'b1);

    for (int mode = 0; mode < 2; mode++) begin
      for (int i = 0; i < 200; i++) begin
        ra = 8'($urandom);
        rb = (i % 25 == 0) ? 8'd0 : 8'($urandom);
        if (rb == 8'd0) begin
          elo = 8'hFF; ehi = ra; ez = 1'b1;
        end else if (mode == 0) begin
          elo = ra / rb; ehi = ra % rb; ez = 1'b0;
        end else begin
          sa = int'($signed(ra)); sb = int'($signed(rb));
          q = sa / sb; r = sa % sb;
          elo = q[7:0]; ehi = r[7:0]; ez = 1'b0;
        end
        op8(mode == 0 ? "rand_u" : "rand_s", mode[0], ra, rb, elo, ehi, ez,
            ez ? 1 : 9, 1'b0);
      end
      $display("op8  random mode=%0d: 200 operations checked", mode);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
